bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arb_pkg.sv | 16 +
 rtl/bus_arb_rr.sv | 23 ++
 rtl/bus_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and constants for the two-master bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_e;

  // Master identifier: 0 = CPU data port, 1 = DMA/debug.
  typedef logic master_id_t;

  // Read data returned to a master whose transaction was aborted by timeout.
  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_arb_rr.sv
// bus_arb_rr: two-way round-robin pick. On a tie the master not granted
// last wins; a lone request always wins.
module bus_arb_rr
  import bus_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  master_id_t last_i,
  output master_id_t gnt_o,
  output logic       gnt_vld_o
);

  // Grant selection from masked requests and last-grant history.
  always_comb begin
    gnt_vld_o = |req_i;
    gnt_o     = 1'b0;
    if (&req_i) begin
      gnt_o = ~last_i;
    end else if (req_i[1]) begin
      gnt_o = 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, single-outstanding shared-bus arbiter.
// Optional feature: define BUS_ARB_TIMEOUT_EN to abort a BUSY phase after
// TimeoutCycles cycles without s_ready_i (ack + err_o, rdata = ABORT_DATA).
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m0_req_i,
  input  logic [DataWidth-1:0] m0_addr_i,
  input  logic [DataWidth-1:0] m0_wdata_i,
  input  logic                 m0_wr_i,
  output logic [DataWidth-1:0] m0_rdata_o,
  output logic                 m0_ack_o,
  input  logic                 m1_req_i,
  input  logic [DataWidth-1:0] m1_addr_i,
  input  logic [DataWidth-1:0] m1_wdata_i,
  input  logic                 m1_wr_i,
  output logic [DataWidth-1:0] m1_rdata_o,
  output logic                 m1_ack_o,
  output logic [DataWidth-1:0] s_addr_o,
  output logic [DataWidth-1:0] s_wdata_o,
  output logic                 s_wr_o,
  output logic                 s_strobe_o,
  input  logic [DataWidth-1:0] s_rdata_i,
  input  logic                 s_ready_i,
  output logic                 err_o
);

  // A zero timeout would abort before the strobe cycle could complete.
  if (TimeoutCycles < 1) begin : g_cfg_chk
    $error("bus_arbiter: TimeoutCycles must be >= 1");
  end

  arb_state_e                      state_q, state_d;
  master_id_t                      last_q, last_d;
  logic [DataWidth-1:0]            addr_q, addr_d;
  logic [DataWidth-1:0]            wdata_q, wdata_d;
  logic                            wr_q, wr_d;
  logic                            strobe_q, strobe_d;
  logic [1:0]                      ack_q, ack_d;
  logic [1:0][DataWidth-1:0]       rdata_q, rdata_d;
  logic [1:0]                      req_m;
  master_id_t                      gnt, owner;
  logic                            gnt_vld;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  // A master being acked this cycle is hidden so its held req is not reissued.
  assign req_m = {m1_req_i & ~ack_q[1], m0_req_i & ~ack_q[0]};
  assign owner = (state_q == BUSY1);

  bus_arb_rr u_rr (
    .req_i    (req_m),
    .last_i   (last_q),
    .gnt_o    (gnt),
    .gnt_vld_o(gnt_vld)
  );

  // Next-state and output computation for the IDLE/BUSY0/BUSY1 FSM.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    strobe_d = 1'b0;
    ack_d    = 2'b00;
    rdata_d  = '0;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // s_ready_i deliberately ignored here.
        if (gnt_vld) begin
          state_d  = gnt ? BUSY1 : BUSY0;
          last_d   = gnt;
          addr_d   = gnt ? m1_addr_i  : m0_addr_i;
          wdata_d  = gnt ? m1_wdata_i : m0_wdata_i;
          wr_d     = gnt ? m1_wr_i    : m0_wr_i;
          strobe_d = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      BUSY0, BUSY1: begin
        if (s_ready_i) begin
          ack_d[owner]   = 1'b1;
          rdata_d[owner] = s_rdata_i;
          wr_d           = 1'b0;
          state_d        = IDLE;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          ack_d[owner]   = 1'b1;
          rdata_d[owner] = DataWidth'(ABORT_DATA);
          err_d          = 1'b1;
          wr_d           = 1'b0;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        wr_d    = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      strobe_q <= 1'b0;
      ack_q    <= 2'b00;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      strobe_q <= strobe_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  // BUSY-cycle counter and abort flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign s_addr_o   = addr_q;
  assign s_wdata_o  = wdata_q;
  assign s_wr_o     = wr_q;
  assign s_strobe_o = strobe_q;
  assign m0_ack_o   = ack_q[0];
  assign m1_ack_o   = ack_q[1];
  assign m0_rdata_o = rdata_q[0];
  assign m1_rdata_o = rdata_q[1];

endmodule
